// File: rtl/traffic_disp_drv.sv
// -----------------------------------------------------------------------------
// traffic_disp_drv
//   Display stage behind the traffic light controller. The module takes one
//   snapshot of the countdown (light_t) and the lamp select (light_ctrl) per
//   scan frame. It decodes the snapshot to decimal digits and drives the lamp
//   LEDs and a 2-digit multiplexed 7-segment display. Each digit slot starts
//   with a dead-time gap in which both digits are off, to avoid ghosting.
//
//   Optional feature: define TRAFFIC_DISP_BLINK_EN to blink the green lamp and
//   the digits while green shows 1..3 seconds left.
//
// Ports
//   sys_clk     in   1  system clock
//   sys_rst_p   in   1  synchronous reset, active-high
//   light_t     in   4  remaining seconds, 0..15
//   light_ctrl  in   3  lamp one-hot {R,Y,G}; 000 = idle
//   seg         out  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACT_LOW
//   dig_en      out  2  digit enable [0]=ones, [1]=tens, polarity per SEG_ACT_LOW
//   led_rgy     out  3  lamp LEDs {R,Y,G}, active-high
// -----------------------------------------------------------------------------
module traffic_disp_drv #(
    parameter int SCAN_DIV    = 50000,
    parameter int DEAD_CYC    = 16,
    parameter int BLINK_DIV   = 12500000,
    parameter bit SEG_ACT_LOW = 1'b1
) (
    input  logic       sys_clk,
    input  logic       sys_rst_p,
    input  logic [3:0] light_t,
    input  logic [2:0] light_ctrl,
    output logic [6:0] seg,
    output logic [1:0] dig_en,
    output logic [2:0] led_rgy
);

    localparam int CW = $clog2(SCAN_DIV);

    localparam logic [0:0] ST_DIG0 = 1'b0;
    localparam logic [0:0] ST_DIG1 = 1'b1;

    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_E    = 7'h79;
    localparam logic [6:0] SEG_ONE  = 7'h06;

    logic [CW-1:0] scan_cnt;
    logic [0:0]    state;
    logic [3:0]    snap_t;
    logic [2:0]    snap_ctrl;

    logic [CW-1:0] nxt_cnt;
    logic [0:0]    nxt_state;
    logic [3:0]    nxt_snap_t;
    logic [2:0]    nxt_snap_ctrl;
    logic          cnt_wrap;
    logic          nxt_blink_ph;

    logic [6:0]    code_ones;
    logic [6:0]    code_tens;
    logic          tens_on;
    logic          gate_on;
    logic          slot_on;
    logic [2:0]    led_nxt;
    logic [6:0]    seg_hi;
    logic [1:0]    dig_hi;

    function automatic logic [6:0] seg7_code(input logic [3:0] d);
        case (d)
            4'd0:    seg7_code = 7'h3F;
            4'd1:    seg7_code = 7'h06;
            4'd2:    seg7_code = 7'h5B;
            4'd3:    seg7_code = 7'h4F;
            4'd4:    seg7_code = 7'h66;
            4'd5:    seg7_code = 7'h6D;
            4'd6:    seg7_code = 7'h7D;
            4'd7:    seg7_code = 7'h07;
            4'd8:    seg7_code = 7'h7F;
            4'd9:    seg7_code = 7'h6F;
            default: seg7_code = 7'h00;
        endcase
    endfunction

    // Outputs are registered but derived from the next-state values, so
    // seg/dig_en line up with the registered scan_cnt with no extra latency.
    always_comb begin
        cnt_wrap      = (scan_cnt == CW'(SCAN_DIV - 1));
        nxt_cnt       = cnt_wrap ? '0 : scan_cnt + CW'(1);
        nxt_state     = cnt_wrap ? ~state : state;
        nxt_snap_t    = snap_t;
        nxt_snap_ctrl = snap_ctrl;
        if (cnt_wrap && state == ST_DIG1) begin
            nxt_snap_t    = light_t;
            nxt_snap_ctrl = light_ctrl;
        end
    end

    always_comb begin
        code_ones = SEG_DASH;
        code_tens = SEG_DASH;
        tens_on   = 1'b1;
        led_nxt   = 3'b000;
        if (nxt_snap_ctrl == 3'b000) begin
            code_ones = SEG_DASH;
            code_tens = SEG_DASH;
        end else if (nxt_snap_ctrl != 3'b001 && nxt_snap_ctrl != 3'b010 &&
                     nxt_snap_ctrl != 3'b100) begin
            code_ones = SEG_E;
            code_tens = SEG_E;
        end else begin
            led_nxt   = nxt_snap_ctrl;
            code_tens = SEG_ONE;
            if (nxt_snap_t >= 4'd10) begin
                code_ones = seg7_code(nxt_snap_t - 4'd10);
            end else begin
                code_ones = seg7_code(nxt_snap_t);
                tens_on   = 1'b0;
            end
        end

        // Blink gating: only green with 1..3 seconds left follows blink_ph.
        gate_on = 1'b1;
        if (nxt_snap_ctrl == 3'b001 && nxt_snap_t >= 4'd1 && nxt_snap_t <= 4'd3) begin
            gate_on = nxt_blink_ph;
        end
        led_nxt[0] = led_nxt[0] & gate_on;

        slot_on = (nxt_cnt >= CW'(DEAD_CYC)) && gate_on &&
                  ((nxt_state == ST_DIG0) || tens_on);
        seg_hi  = '0;
        dig_hi  = '0;
        if (slot_on) begin
            if (nxt_state == ST_DIG0) begin
                seg_hi = code_ones;
                dig_hi = 2'b01;
            end else begin
                seg_hi = code_tens;
                dig_hi = 2'b10;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst_p) begin
            scan_cnt  <= '0;
            state     <= ST_DIG0;
            snap_t    <= '0;
            snap_ctrl <= '0;
            seg       <= SEG_ACT_LOW ? '1 : '0;
            dig_en    <= SEG_ACT_LOW ? '1 : '0;
            led_rgy   <= '0;
        end else begin
            scan_cnt  <= nxt_cnt;
            state     <= nxt_state;
            snap_t    <= nxt_snap_t;
            snap_ctrl <= nxt_snap_ctrl;
            seg       <= SEG_ACT_LOW ? ~seg_hi : seg_hi;
            dig_en    <= SEG_ACT_LOW ? ~dig_hi : dig_hi;
            led_rgy   <= led_nxt;
        end
    end

`ifdef TRAFFIC_DISP_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0] blink_cnt;
    logic          blink_ph;
    logic          blink_wrap;

    assign blink_wrap   = (blink_cnt == BW'(BLINK_DIV - 1));
    assign nxt_blink_ph = blink_wrap ? ~blink_ph : blink_ph;

    always_ff @(posedge sys_clk) begin
        if (sys_rst_p) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b1;
        end else begin
            blink_cnt <= blink_wrap ? '0 : blink_cnt + BW'(1);
            blink_ph  <= nxt_blink_ph;
        end
    end
`else
    // Without blinking the phase is held on; BLINK_DIV has no role here.
    logic unused_blink_div;
    assign unused_blink_div = |BLINK_DIV;
    assign nxt_blink_ph     = 1'b1;
`endif

endmodule

// File: tb/tb_traffic_disp_drv.sv
// -----------------------------------------------------------------------------
// tb_traffic_disp_drv
//   Self-checking bench for traffic_disp_drv. A frame-position reference
//   model advances on every clock and pushes the expected outputs into a
//   queue. The queue is popped and compared against the DUT on the falling
//   edge.
// -----------------------------------------------------------------------------
module tb_traffic_disp_drv;

    localparam int SD = 8;
    localparam int DC = 2;
    localparam int BD = 32;

    logic       sys_clk = 1'b0;
    logic       sys_rst_p;
    logic [3:0] light_t;
    logic [2:0] light_ctrl;
    logic [6:0] seg;
    logic [1:0] dig_en;
    logic [2:0] led_rgy;

    traffic_disp_drv #(
        .SCAN_DIV    (SD),
        .DEAD_CYC    (DC),
        .BLINK_DIV   (BD),
        .SEG_ACT_LOW (1'b1)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_p  (sys_rst_p),
        .light_t    (light_t),
        .light_ctrl (light_ctrl),
        .seg        (seg),
        .dig_en     (dig_en),
        .led_rgy    (led_rgy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [6:0] seg;
        logic [1:0] dig;
        logic [2:0] led;
        bit         seg_valid;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    int         pos;
    logic [3:0] m_t;
    logic [2:0] m_c;
    int         bcnt;
    bit         bph;

    const logic [6:0] dig_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                       7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    function automatic exp_t model_out(input int p, input logic [3:0] t,
                                       input logic [2:0] c, input bit ph);
        exp_t e;
        int   slot, off;
        bit   on, gate;
        logic [6:0] code;
        slot = p / SD;
        off  = p % SD;
        on   = (off >= DC);
        e.led = 3'b000;
        if (c == 3'b000) begin
            code = 7'h40;
        end else if (!(c == 3'b001 || c == 3'b010 || c == 3'b100)) begin
            code = 7'h79;
        end else begin
            e.led = c;
            if (slot == 0) code = (t >= 10) ? dig_tab[t - 10] : dig_tab[t];
            else begin
                code = 7'h06;
                if (t < 10) on = 1'b0;
            end
        end
        gate = 1'b1;
`ifdef TRAFFIC_DISP_BLINK_EN
        if (c == 3'b001 && t >= 1 && t <= 3) gate = ph;
`else
        if (ph) gate = 1'b1;
`endif
        e.led[0] = e.led[0] & gate;
        on = on & gate;
        e.seg       = ~code;
        e.dig       = on ? ((slot == 0) ? 2'b10 : 2'b01) : 2'b11;
        e.seg_valid = on;
        return e;
    endfunction

    always @(posedge sys_clk) begin
        exp_t e;
        if (sys_rst_p) begin
            pos  = 0;
            m_t  = '0;
            m_c  = '0;
            bcnt = 0;
            bph  = 1'b1;
            e.seg = 7'h7F; e.dig = 2'b11; e.led = 3'b000; e.seg_valid = 1'b1;
        end else begin
            if (pos == 2 * SD - 1) begin
                pos = 0;
                m_t = light_t;
                m_c = light_ctrl;
            end else begin
                pos++;
            end
            if (bcnt == BD - 1) begin
                bcnt = 0;
                bph  = !bph;
            end else begin
                bcnt++;
            end
            e = model_out(pos, m_t, m_c, bph);
        end
        exp_q.push_back(e);
    end

    always @(negedge sys_clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val("dig_en", int'(dig_en), int'(e.dig));
            check_val("led_rgy", int'(led_rgy), int'(e.led));
            if (e.seg_valid) check_val("seg", int'(seg), int'(e.seg));
            check_val("dig_excl", int'(dig_en != 2'b00), 1);
        end
    end

    task automatic run_cycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    initial begin
        bit found;
        sys_rst_p  = 1'b1;
        light_t    = 4'd0;
        light_ctrl = 3'b000;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_p = 1'b0;

        // Two-digit value, green
        light_t = 4'd12; light_ctrl = 3'b001;
        run_cycles(3 * 2 * SD);

        // Single digit, red: tens slot stays dark
        light_t = 4'd7; light_ctrl = 3'b100;
        run_cycles(3 * 2 * SD);

        // Mid-frame input change must not tear the display
        light_t = 4'd12; light_ctrl = 3'b001;
        run_cycles(2 * SD);
        found = 1'b0;
        for (int i = 0; i < 4 * SD; i++) begin
            if (pos == 3) begin
                found = 1'b1;
                break;
            end
            @(negedge sys_clk);
        end
        check_val("wait_pos3", int'(found), 1);
        light_t = 4'd11;
        run_cycles(3 * 2 * SD);

        // Idle then invalid lamp select
        light_ctrl = 3'b000;
        run_cycles(3 * 2 * SD);
        light_ctrl = 3'b011;
        run_cycles(3 * 2 * SD);

        // Reset mid-frame aborts the slot
        light_t = 4'd9; light_ctrl = 3'b010;
        run_cycles(2 * SD + 5);
        sys_rst_p = 1'b1;
        run_cycles(2);
        sys_rst_p = 1'b0;
        run_cycles(3 * 2 * SD);

        // Blink window (steady without the macro), then steady value
        light_t = 4'd2; light_ctrl = 3'b001;
        run_cycles(5 * BD);
        light_t = 4'd4;
        run_cycles(2 * BD);

        run_cycles(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit 200000 reached");
        $fatal(1);
    end

endmodule
